// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port synchronous memory between
// instruction fetch and load/store, with data priority and a fetch starvation guard.
module imem_dmem_arbiter #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        stall_if_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    localparam logic [CW-1:0] CNT_LAT = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [SW-1:0] STK_MAX = SW'(MAX_D_STREAK);
    localparam logic [SW-1:0] STK_ONE = SW'(1);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    owner_e        owner_q;
    owner_e        owner_nxt;
    logic          we_q;
    logic          we_nxt;
    logic          flushed_q;
    logic          flushed_nxt;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_nxt;

    logic free;
    logic busy;
    logic rsp;
    logic force_if;
    logic grant_d;
    logic grant_if;
    logic if_rv;
    logic d_rv;

    // Slot availability and data-first arbitration with forced fetch after a streak
    always_comb begin
        busy     = (cnt_q != '0);
        rsp      = (cnt_q == CNT_ONE);
        free     = ~busy | rsp;
        force_if = (streak_q == STK_MAX);
        grant_d  = free & d_req_i & ~(if_req_i & force_if);
        grant_if = free & if_req_i & ~grant_d;
        if_rv    = rsp & (owner_q == OWN_IF) & ~flushed_q & ~if_flush_i;
        d_rv     = rsp & (owner_q == OWN_D);
    end

    // Outputs: grant/response routing and memory mux, all forced low in reset
    always_comb begin
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        stall_if_o  = 1'b0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (reset_n) begin
            if_gnt_o    = grant_if;
            d_gnt_o     = grant_d;
            stall_if_o  = if_req_i & ~grant_if;
            if_rvalid_o = if_rv;
            d_rvalid_o  = d_rv;
            if (if_rv) begin
                if_rdata_o = mem_rdata_i;
            end
            if (d_rv & ~we_q) begin
                d_rdata_o = mem_rdata_i;
            end
            mem_req_o = grant_if | grant_d;
            unique case (1'b1)
                grant_d: begin
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                end
                grant_if: begin
                    mem_we_o    = 1'b0;
                    mem_be_o    = 4'hF;
                    mem_addr_o  = if_addr_i;
                    mem_wdata_o = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state: occupancy countdown, owner, flush marking and streak tracking
    always_comb begin
        cnt_nxt     = cnt_q;
        owner_nxt   = owner_q;
        we_nxt      = we_q;
        flushed_nxt = flushed_q;
        streak_nxt  = streak_q;
        if (grant_d | grant_if) begin
            cnt_nxt     = CNT_LAT;
            owner_nxt   = grant_d ? OWN_D : OWN_IF;
            we_nxt      = grant_d & d_we_i;
            flushed_nxt = 1'b0;
        end else begin
            if (busy) begin
                cnt_nxt = cnt_q - CNT_ONE;
            end
            if (if_flush_i & busy & (owner_q == OWN_IF)) begin
                flushed_nxt = 1'b1;
            end
        end
        if (~if_req_i | grant_if) begin
            streak_nxt = '0;
        end else if (grant_d & (streak_q != STK_MAX)) begin
            streak_nxt = streak_q + STK_ONE;
        end
    end

    // State registers; reset drops any in-flight response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            flushed_q <= 1'b0;
            streak_q  <= '0;
        end else begin
            cnt_q     <= cnt_nxt;
            owner_q   <= owner_nxt;
            we_q      <= we_nxt;
            flushed_q <= flushed_nxt;
            streak_q  <= streak_nxt;
        end
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction fetch stage (read-only requester) and the load/store stage (read/write requester).
- Keeps at most one transaction per LATENCY cycles in flight, routes each response back to its owner, and generates the fetch stall.
- Data port has priority, with a starvation guard that periodically forces a fetch grant.
- Sits between the pipeline and the unified memory.

Parameters:
LATENCY, 1, memory read latency in cycles (>=1); the response is sampled LATENCY cycles after the grant cycle.
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced (>=1).

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req_i  in  1  fetch requests a read
if_addr_i  in  32  fetch address
if_flush_i  in  1  discard the outstanding fetch response (branch/redirect)
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch response valid
if_rdata_o  out  32  fetch response data (0 when not valid)
stall_if_o  out  1  if_req_i & ~if_gnt_o
d_req_i  in  1  data request
d_we_i  in  1  1=write, 0=read
d_be_i  in  4  byte enables
d_addr_i  in  32  data address
d_wdata_i  in  32  write data
d_gnt_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  data response valid (also acks writes)
d_rdata_o  out  32  read data (0 on write ack or when not valid)
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data

Behaviour:
- Internal state:
  - cnt (width clog2(LATENCY+1)).
  - owner (IF/D).
  - flushed flag.
  - streak counter (width clog2(MAX_D_STREAK+1)).
- Async reset: cnt=0, owner=IF, flushed=0, streak=0. All outputs are 0 during reset. Any in-flight response is dropped, never delivered.
- free = (cnt==0) | (cnt==1). A grant may coincide with a completing response, giving back-to-back issue; LATENCY=1 gives one transaction per cycle.
- Arbitration (combinational, only when free):
  - d_req_i only -> D.
  - if_req_i only -> IF.
  - Both -> D, unless streak==MAX_D_STREAK, then IF.
  - Grants are the only acceptance; a requester holds req and its payload stable until granted.
- mem_* muxes the granted requester's signals; mem_req_o = if_gnt_o | d_gnt_o.
  - Fetch: mem_we_o=0, mem_be_o=4'hF.
  - No grant: all mem_* are 0.
- On a grant edge: cnt<=LATENCY, owner<=granted port, flushed<=0.
- Otherwise, if cnt!=0: cnt<=cnt-1.
- Response: in the cycle cnt==1, owner's rvalid=1 and its rdata=mem_rdata_i (D write: rdata=0). Timing: grant in cycle T -> rvalid in cycle T+LATENCY.
- Flush:
  - if_flush_i while owner==IF and cnt!=0 -> flushed<=1.
  - If_flush_i in the cycle cnt==1 also suppresses if_rvalid_o combinationally.
  - if_rvalid_o = (cnt==1) & owner==IF & ~flushed & ~if_flush_i.
  - Flush does not shorten occupancy and does not block a fetch grant in the same cycle; the new grant's response is not suppressed.
- Streak:
  - Increments (saturating) on each D grant while if_req_i=1 and IF not granted.
  - Clears on IF grant, or any cycle with if_req_i=0.
- stall_if_o is asserted whenever fetch requests and is not granted, including while busy.
- A D write is performed by memory at the grant edge; no read data is returned.

Test Plan:
- LATENCY=1, if_req_i held high, if_addr_i 0x0,0x4,0x8 -> if_gnt_o every cycle; if_rvalid_o one cycle after each grant with mem data; stall_if_o=0.
- LATENCY=2, d_req_i and if_req_i both high from cycle 0 -> D granted cycle 0; IF waits (stall_if_o=1); d_rvalid_o at cycle 2; next grant in cycle 2.
- MAX_D_STREAK=4, both requesting continuously -> grant pattern D,D,D,D,IF repeating; streak clears after the IF grant.
- D write, addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> mem_we_o=1, mem_be_o=0011 in grant cycle; d_rvalid_o=1 with d_rdata_o=0 after LATENCY.
- LATENCY=3, IF granted at cycle 0, if_flush_i pulse at cycle 1 -> no if_rvalid_o at cycle 3; a new IF grant at cycle 3 returns valid at cycle 6.
- reset_n low asynchronously at cycle 1 of a LATENCY=3 transaction -> all outputs 0 immediately; no rvalid after release; first grant is available in the first cycle after release.
